// File: rtl/fredkin_pkg.sv
// Shared definitions for the Fredkin controlled-swap scrambler and unscrambler.
package fredkin_pkg;

  parameter int unsigned DefaultW      = 8;
  parameter int unsigned DefaultStages = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Lower bit index of pair i: adjacent bits on even stages, half-word apart on odd stages.
  function automatic int unsigned pair_lo(input int unsigned w, input logic odd_stage,
                                          input int unsigned i);
    if (odd_stage) begin
      return i;
    end
    return 2 * i;
  endfunction

  // Upper bit index of pair i.
  function automatic int unsigned pair_hi(input int unsigned w, input logic odd_stage,
                                          input int unsigned i);
    if (odd_stage) begin
      return i + w / 2;
    end
    return 2 * i + 1;
  endfunction

endpackage

// File: rtl/fredkin_stage.sv
// One combinational swap stage: W/2 Fredkin gates, pairing chosen by stage parity.
module fredkin_stage
  import fredkin_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic           odd,
  input  logic [W/2-1:0] ctrl,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout
);

  logic [W-1:0] even_res;
  logic [W-1:0] odd_res;

  for (genvar i = 0; i < W / 2; i++) begin : g_pair
    localparam int unsigned ELo = pair_lo(W, 1'b0, i);
    localparam int unsigned EHi = pair_hi(W, 1'b0, i);
    localparam int unsigned OLo = pair_lo(W, 1'b1, i);
    localparam int unsigned OHi = pair_hi(W, 1'b1, i);

    // Fredkin gate with control ctrl[i]: swap the pair when set, pass through otherwise.
    assign even_res[ELo] = ctrl[i] ? din[EHi] : din[ELo];
    assign even_res[EHi] = ctrl[i] ? din[ELo] : din[EHi];
    assign odd_res[OLo]  = ctrl[i] ? din[OHi] : din[OLo];
    assign odd_res[OHi]  = ctrl[i] ? din[OLo] : din[OHi];
  end

  assign dout = odd ? odd_res : even_res;

endmodule

// File: rtl/fredkin_unscrambler.sv
// Sequential inverse of the Fredkin scrambling network: applies one stage per clock,
// from the last stage down to stage 0, behind valid/ready handshakes.
module fredkin_unscrambler
  import fredkin_pkg::*;
#(
  parameter int unsigned W      = DefaultW,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic [STAGES*W/2-1:0] in_key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data
);

  localparam int unsigned KW   = STAGES * W / 2;
  localparam int unsigned H    = W / 2;
  localparam int unsigned CntW = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    work_q;
  logic [KW-1:0]   key_q;
  logic [CntW-1:0] cnt_q;

  logic [H-1:0]    ctrl_sel;
  logic [W-1:0]    stage_out;

  // Select the key slice of the stage addressed by cnt.
  always_comb begin
    ctrl_sel = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      if (cnt_q == CntW'(s)) begin
        ctrl_sel = key_q[s*H +: H];
      end
    end
  end

  fredkin_stage #(
    .W (W)
  ) u_stage (
    .odd  (cnt_q[0]),
    .ctrl (ctrl_sel),
    .din  (work_q),
    .dout (stage_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StRun;
      StRun:  if (cnt_q == '0) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: latch word and key on accept, then step one stage per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      key_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q <= in_data;
            key_q  <= in_key;
            cnt_q  <= CntW'(STAGES - 1);
          end
        end
        StRun: begin
          work_q <= stage_out;
          // Exit at zero, so the decrement never wraps.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_data  = (state_q == StDone) ? work_q : '0;
  end

endmodule

// File: tb/tb_fredkin_unscrambler.sv
// Self-checking bench for fredkin_unscrambler (W=8, STAGES=4).
module tb_fredkin_unscrambler;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 4;
  localparam int unsigned KW = S * W / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [KW-1:0] in_key;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  int errors = 0;
  int checks = 0;

  fredkin_unscrambler #(
    .W      (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] key;
    logic [W-1:0]  expect_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Reference: one stage as a permutation of a bit array.
  function automatic logic [W-1:0] ref_stage(input logic [W-1:0] v, input logic [KW-1:0] k,
                                             input int s);
    logic [W-1:0] r;
    int a, b;
    logic t;
    r = v;
    for (int i = 0; i < int'(W / 2); i++) begin
      if (k[s * (W / 2) + i]) begin
        a = (s % 2 == 0) ? 2 * i : i;
        b = (s % 2 == 0) ? 2 * i + 1 : i + W / 2;
        t = r[a];
        r[a] = r[b];
        r[b] = t;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_scramble(input logic [W-1:0] d, input logic [KW-1:0] k);
    logic [W-1:0] v;
    v = d;
    for (int s = 0; s < int'(S); s++) v = ref_stage(v, k, s);
    return v;
  endfunction

  // Accept one word, measure latency to out_valid, check result, then drain (out_ready=1).
  task automatic run_txn(input logic [W-1:0] d, input logic [KW-1:0] k,
                         input logic [W-1:0] want, input string name);
    int lat;
    check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_key    = k;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    // Disturb the inputs: the latched copies must be used.
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_key   = KW'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(S));
    check({name, " data"}, 32'(out_data), 32'(want));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    vecs = '{
      '{8'hA5, 16'h0000, 8'hA5},
      '{8'h01, 16'h0001, 8'h02},
      '{8'h01, 16'h0010, 8'h10},
      '{8'h02, 16'h0011, 8'h01},
      '{8'h01, 16'h0100, 8'h02},
      '{8'h01, 16'h1000, 8'h10},
      '{8'h0F, 16'hFFFF, 8'h0F},
      '{8'h40, 16'h0008, 8'h80}
    };

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    foreach (vecs[n]) begin
      run_txn(vecs[n].data, vecs[n].key, vecs[n].expect_data, $sformatf("vec%0d", n));
    end

    // Random round trips through the forward reference.
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0]  plain;
      logic [KW-1:0] key;
      plain = W'($urandom);
      key   = KW'($urandom);
      run_txn(ref_scramble(plain, key), key, plain, $sformatf("rand%0d", n));
    end

    // Back-pressure: hold DONE for 10 cycles, an in_valid pulse must be ignored.
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_key    = 16'h0001;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 10; c++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_data", 32'(out_data), 32'h02);
      check("bp in_ready", 32'(in_ready), 32'd0);
      in_valid = (c == 3);
      in_data  = 8'hFF;
      in_key   = 16'hFFFF;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp idle holds", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_key   = 16'h5A5A;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid-run rst out_valid", 32'(out_valid), 32'd0);
    check("mid-run rst out_data", 32'(out_data), 32'd0);
    check("mid-run rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_txn(8'h01, 16'h0001, 8'h02, "post-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
